// File: rtl/grf_wb_pkg.sv
// grf_wb_pkg: shared widths and the queue entry type for the GRF
// write-back merge queue (grf_wb_queue, grf_wb_lookup).
package grf_wb_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    // One buffered secondary write. valid=0 marks an entry that was
    // killed (or discarded at enqueue) but still occupies its slot.
    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

endpackage

// File: rtl/grf_wb_lookup.sv
// grf_wb_lookup: combinational youngest-first match over the queue
// entries, used by stall/forward logic.
// Ports:
//   i_entries  queue storage (indexed by low pointer bits)
//   i_head     read pointer with wrap bit
//   i_tail     write pointer with wrap bit
//   i_addr     register being looked up (0 never hits)
//   o_hit      a valid occupied entry targets i_addr
//   o_data     data of the youngest such entry, 0 on miss
module grf_wb_lookup
    import grf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  wb_entry_t          i_entries [DEPTH],
    input  logic [PW:0]        i_head,
    input  logic [PW:0]        i_tail,
    input  logic [REG_W-1:0]   i_addr,
    output logic               o_hit,
    output logic [DATA_W-1:0]  o_data
);

    logic [PW:0]   w_occ;
    logic [PW-1:0] w_idx;

    // Walk oldest to youngest; a later match overrides, so the result
    // belongs to the youngest matching entry.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        w_occ  = i_tail - i_head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = i_head[PW-1:0] + PW'(k);
            if (((PW+1)'(k) < w_occ) && i_entries[w_idx].valid &&
                (i_entries[w_idx].a3 == i_addr) && (i_addr != '0)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].wd;
            end
        end
    end

endmodule

// File: rtl/grf_wb_queue.sv
// grf_wb_queue: write-back merge queue in front of the single GRF write
// port. Primary writes pass straight through; secondary writes are
// buffered and drained in idle primary cycles.
// Optional macro GRF_WB_TRACE_EN: prints the commit trace on each edge
// with a GRF write to a non-zero register.
// Ports:
//   clk, reset (active-low async)
//   pri_we/pri_a3/pri_wd/pri_pc      primary write source
//   sec_valid/sec_ready/sec_a3/sec_wd/sec_pc  secondary handshake source
//   grf_we/grf_a3/grf_wd/grf_pc      GRF write port
//   q_addr/q_hit/q_data              pending-value lookup
//   q_empty                          no valid entries queued
module grf_wb_queue
    import grf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pri_we,
    input  logic [REG_W-1:0]  pri_a3,
    input  logic [DATA_W-1:0] pri_wd,
    input  logic [DATA_W-1:0] pri_pc,
    input  logic              sec_valid,
    output logic              sec_ready,
    input  logic [REG_W-1:0]  sec_a3,
    input  logic [DATA_W-1:0] sec_wd,
    input  logic [DATA_W-1:0] sec_pc,
    output logic              grf_we,
    output logic [REG_W-1:0]  grf_a3,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc,
    input  logic [REG_W-1:0]  q_addr,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data,
    output logic              q_empty
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
    localparam logic [PW:0] FULL    = (PW+1)'(DEPTH);

    wb_entry_t     r_q [DEPTH];
    logic [PW:0]   r_head;
    logic [PW:0]   r_tail;

    logic [PW:0]   w_occ;
    logic [PW-1:0] w_hidx;
    logic [PW-1:0] w_tidx;
    wb_entry_t     w_head;
    logic          w_pri_eff;
    logic          w_pop;
    logic          w_push;
    logic          w_new_valid;
    logic          w_any_valid;

    assign w_occ     = r_tail - r_head;
    assign w_hidx    = r_head[PW-1:0];
    assign w_tidx    = r_tail[PW-1:0];
    assign w_head    = r_q[w_hidx];
    assign w_pri_eff = pri_we && (pri_a3 != '0);
    assign sec_ready = (w_occ != FULL);
    assign w_pop     = !w_pri_eff && (w_occ != '0);
    assign w_push    = sec_valid && sec_ready;
    // Discarded writes (a3=0, or killed by the same-cycle primary) still
    // take a slot so occupancy stays a pure push/pop count.
    assign w_new_valid = (sec_a3 != '0) && !(w_pri_eff && (pri_a3 == sec_a3));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head <= '0;
            r_tail <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_pri_eff && (r_q[i].a3 == pri_a3)) r_q[i].valid <= 1'b0;
            end
            if (w_pop) begin
                r_q[w_hidx].valid <= 1'b0;
                r_head <= r_head + PTR_ONE;
            end
            // Push never targets an occupied slot (sec_ready=0 when full),
            // so it safely overrides the kill/pop clears above.
            if (w_push) begin
                r_q[w_tidx] <= '{valid: w_new_valid, a3: sec_a3, wd: sec_wd, pc: sec_pc};
                r_tail <= r_tail + PTR_ONE;
            end
        end
    end

    // Output mux gated by reset so no write is presented while in reset.
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = '0;
        if (reset) begin
            if (w_pri_eff) begin
                grf_we = 1'b1;
                grf_a3 = pri_a3;
                grf_wd = pri_wd;
                grf_pc = pri_pc;
            end else if (w_pop && w_head.valid) begin
                grf_we = 1'b1;
                grf_a3 = w_head.a3;
                grf_wd = w_head.wd;
                grf_pc = w_head.pc;
            end
        end
    end

    // Popped and killed slots have valid cleared, so a flat OR suffices.
    always_comb begin
        w_any_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) w_any_valid = w_any_valid | r_q[i].valid;
    end
    assign q_empty = ~w_any_valid;

    grf_wb_lookup #(.DEPTH(DEPTH)) u_lookup (
        .i_entries (r_q),
        .i_head    (r_head),
        .i_tail    (r_tail),
        .i_addr    (q_addr),
        .o_hit     (q_hit),
        .o_data    (q_data)
    );

`ifdef GRF_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (grf_we && (grf_a3 != '0))
            $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_wd);
    end
`endif

endmodule

// File: tb/tb_grf_wb_queue.sv
module tb_grf_wb_queue;
    import grf_wb_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              pri_we;
    logic [REG_W-1:0]  pri_a3;
    logic [DATA_W-1:0] pri_wd, pri_pc;
    logic              sec_valid, sec_ready;
    logic [REG_W-1:0]  sec_a3;
    logic [DATA_W-1:0] sec_wd, sec_pc;
    logic              grf_we;
    logic [REG_W-1:0]  grf_a3;
    logic [DATA_W-1:0] grf_wd, grf_pc;
    logic [REG_W-1:0]  q_addr;
    logic              q_hit;
    logic [DATA_W-1:0] q_data;
    logic              q_empty;

    grf_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .pri_we(pri_we), .pri_a3(pri_a3), .pri_wd(pri_wd), .pri_pc(pri_pc),
        .sec_valid(sec_valid), .sec_ready(sec_ready),
        .sec_a3(sec_a3), .sec_wd(sec_wd), .sec_pc(sec_pc),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .q_empty(q_empty)
    );

    always #5 clk = ~clk;

    // Reference model: in-order list of pending secondary writes.
    typedef struct {
        logic        v;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ment_t;

    ment_t mq[$];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic [31:0] ppc, input logic sv, input logic [4:0] sa,
                         input logic [31:0] sd, input logic [31:0] spc, input logic [4:0] qa);
        pri_we = pw; pri_a3 = pa; pri_wd = pd; pri_pc = ppc;
        sec_valid = sv; sec_a3 = sa; sec_wd = sd; sec_pc = spc;
        q_addr = qa;
    endtask

    task automatic idle(input logic [4:0] qa);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, qa);
    endtask

    task automatic chk_reset_values();
        chk("rst_grf_we", grf_we, 0);
        chk("rst_grf_a3", grf_a3, 0);
        chk("rst_grf_wd", grf_wd, 0);
        chk("rst_grf_pc", grf_pc, 0);
        chk("rst_sec_ready", sec_ready, 1);
        chk("rst_q_hit", q_hit, 0);
        chk("rst_q_data", q_data, 0);
        chk("rst_q_empty", q_empty, 1);
    endtask

    // Called just after a falling edge with inputs applied: checks all
    // outputs against the model, then advances the model past the rising
    // edge and waits for the next falling edge.
    task automatic step();
        logic        pe, e_we, e_rdy, e_hit, e_emp;
        logic [4:0]  e_a3;
        logic [31:0] e_wd, e_pc, e_qd;
        ment_t       ne;
        #1;
        pe    = pri_we && (pri_a3 != 0);
        e_rdy = (mq.size() < DEPTH);
        e_we = 0; e_a3 = 0; e_wd = 0; e_pc = 0;
        if (pe) begin
            e_we = 1; e_a3 = pri_a3; e_wd = pri_wd; e_pc = pri_pc;
        end else if (mq.size() > 0 && mq[0].v) begin
            e_we = 1; e_a3 = mq[0].a3; e_wd = mq[0].wd; e_pc = mq[0].pc;
        end
        e_hit = 0; e_qd = 0; e_emp = 1;
        foreach (mq[i]) begin
            if (mq[i].v) e_emp = 0;
            if (mq[i].v && q_addr != 0 && mq[i].a3 == q_addr) begin
                e_hit = 1; e_qd = mq[i].wd;
            end
        end
        chk("grf_we", grf_we, e_we);
        chk("grf_a3", grf_a3, e_a3);
        chk("grf_wd", grf_wd, e_wd);
        chk("grf_pc", grf_pc, e_pc);
        chk("sec_ready", sec_ready, e_rdy);
        chk("q_hit", q_hit, e_hit);
        chk("q_data", q_data, e_qd);
        chk("q_empty", q_empty, e_emp);
        if (pe) foreach (mq[i]) if (mq[i].a3 == pri_a3) mq[i].v = 0;
        if (!pe && mq.size() > 0) void'(mq.pop_front());
        if (sec_valid && e_rdy) begin
            ne.v  = (sec_a3 != 0) && !(pe && sec_a3 == pri_a3);
            ne.a3 = sec_a3; ne.wd = sec_wd; ne.pc = sec_pc;
            mq.push_back(ne);
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        idle(5'd0);
        #3;
        chk_reset_values();
        @(negedge clk);
        reset = 1'b1;

        // Single secondary write lands one cycle after acceptance
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5, 32'h11, 32'h3000, 5'd5);
        step();
        idle(5'd5);
        #1;
        chk("tp1_we", grf_we, 1);
        chk("tp1_a3", grf_a3, 5);
        chk("tp1_wd", grf_wd, 32'h11);
        chk("tp1_pc", grf_pc, 32'h3000);
        step();
        #1;
        chk("tp1_empty_after", q_empty, 1);
        step();

        // Fill under continuous primary traffic, then drain in order
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd1, 32'h100 + i, 32'h1000 + 4 * i,
                  1'b1, 5'(10 + i), 32'h200 + i, 32'h2000 + 4 * i, 5'd10);
            step();
        end
        drive(1'b1, 5'd1, 32'h1ff, 32'h1ffc, 1'b0, 5'd0, 32'd0, 32'd0, 5'd13);
        #1;
        chk("tp2_full_ready", sec_ready, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            idle(5'd12);
            step();
        end

        // Primary kills a queued entry to the same register
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd8, 32'hAA, 32'h4000, 5'd8);
        step();
        drive(1'b1, 5'd8, 32'hBB, 32'h4004, 1'b0, 5'd0, 32'd0, 32'd0, 5'd8);
        #1;
        chk("tp3_hit_before", q_hit, 1);
        step();
        idle(5'd8);
        #1;
        chk("tp3_killed_pop_we", grf_we, 0);
        chk("tp3_hit_after", q_hit, 0);
        step();

        // Youngest match wins; register 0 never hits
        drive(1'b1, 5'd1, 32'd1, 32'd0, 1'b1, 5'd9, 32'h1, 32'h5000, 5'd9);
        step();
        drive(1'b1, 5'd1, 32'd2, 32'd0, 1'b1, 5'd9, 32'h2, 32'h5004, 5'd9);
        step();
        drive(1'b1, 5'd1, 32'd3, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd9);
        #1;
        chk("tp4_hit", q_hit, 1);
        chk("tp4_data", q_data, 32'h2);
        step();
        drive(1'b1, 5'd1, 32'd4, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        step();

        // Primary to r0 is idle: queue drains; sec_a3=0 never written
        drive(1'b1, 5'd0, 32'hDEAD, 32'd0, 1'b1, 5'd0, 32'h77, 32'h6000, 5'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd0, 32'hBEEF, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd9);
            step();
        end

        // Asynchronous reset mid-cycle with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd2, 32'h300 + i, 32'd0, 1'b1, 5'(20 + i), 32'h400 + i, 32'h7000 + 4 * i, 5'd20);
            step();
        end
        drive(1'b1, 5'd3, 32'h555, 32'h8000, 1'b1, 5'd21, 32'h666, 32'h8004, 5'd21);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_values();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        for (int i = 0; i < 3; i++) begin
            idle(5'(20 + i));
            step();
        end

        // Randomized traffic over a small register range
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom, $urandom,
                  ($urandom_range(0, 99) < 70), 5'($urandom_range(0, 7)), $urandom, $urandom,
                  5'($urandom_range(0, 7)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_wb_queue.md
# grf_wb_queue

Write-back merge queue in front of the GRF write port. Registers the CPU commits through two write sources: a primary source (ALU/load result, one per cycle, never stalled) and a secondary source (long-latency unit results, valid/ready handshake). Secondary writes are buffered and drained into the single GRF write port in idle primary cycles. A lookup port exposes pending secondary values to the stall/forward logic.

## Interface
- DEPTH, 4: secondary queue entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- reset  in  1  active-low, asynchronous; 0 = in reset
- pri_we  in  1  primary write request this cycle
- pri_a3  in  5  primary destination register
- pri_wd  in  32  primary write data
- pri_pc  in  32  PC of primary instruction
- sec_valid  in  1  secondary write offered
- sec_ready  out  1  queue can accept this cycle
- sec_a3  in  5  secondary destination register
- sec_wd  in  32  secondary write data
- sec_pc  in  32  PC of secondary instruction
- grf_we  out  1  GRF write enable
- grf_a3  out  5  GRF write address
- grf_wd  out  32  GRF write data
- grf_pc  out  32  PC tagged with the write
- q_addr  in  5  lookup register
- q_hit  out  1  valid queued entry targets q_addr
- q_data  out  32  data of youngest matching entry
- q_empty  out  1  no valid entries queued

## Operation
- Primary is effective only when pri_we=1 and pri_a3≠0; otherwise the cycle is idle.
- Effective primary: grf_* driven from pri_* combinationally, queue holds.
- Idle primary and valid head entry: grf_* driven from head, head popped at clock edge.
- Idle primary and killed head: head popped, grf_we=0.
- Enqueue on edge when sec_valid & sec_ready; sec_a3=0 is accepted and discarded.
- Kill rule: primary is program-order younger than every secondary entry. Effective primary to register X clears the valid bit of every queued entry with a3=X. An entry enqueued in the same cycle with sec_a3=X is accepted and discarded.
- sec_ready = (occupancy < DEPTH). Occupancy counts killed entries until they are popped.
- Lookup: q_hit/q_data from the youngest valid entry with a3=q_addr. q_addr=0 → q_hit=0. Miss → q_data=0. Purely combinational; reflects pre-edge state.
- q_empty = no valid entries. Killed-only queue reports empty.

## Timing
- Primary write: zero latency, combinational pass-through.
- Secondary write: earliest GRF write one cycle after acceptance.
- Pop and push in the same cycle are allowed.
- sec_ready depends only on registered occupancy; when full it stays 0 even on a popping cycle. No valid→ready combinational path.
- Pointers wrap modulo DEPTH. An extra occupancy bit distinguishes full from empty.
- Reset (asynchronous, any time): queue flushed, all valid bits 0, pointers 0.
  - Reset values: grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0, sec_ready=1, q_hit=0, q_data=0, q_empty=1.
  - Entries in flight are lost; no GRF write occurs during reset.

## Configuration
- GRF_WB_TRACE_EN defined: at each clock edge with grf_we=1 and grf_a3≠0, print "%d@%h: $%d <= %h" (time, grf_pc, grf_a3, grf_wd). This is the standard commit trace.
- GRF_WB_TRACE_EN undefined: no simulation output; RTL is otherwise identical.

## Structure
- Package grf_wb_pkg holds:
  - REG_W=5 and DATA_W=32.
  - typedef wb_entry_t {valid, a3, wd, pc}.
- Sub-module grf_wb_lookup: combinational youngest-first match over the entry array. Parameterised by DEPTH; takes entries plus head/tail pointers; returns hit and data.
- Queue storage, pointers, kill logic and output mux stay in grf_wb_queue.

## Test plan
- Reset, then secondary write {a3=5, wd=0x11, pc=0x3000} with pri_we=0 → next cycle grf_we=1, grf_a3=5, grf_wd=0x11, grf_pc=0x3000; q_empty=1 after.
- Fill DEPTH=4 with pri_we=1 (a3=1) every cycle → sec_ready=0 after 4 accepts. Drop pri_we → 4 writes in order, one per cycle; sec_ready returns 1 the cycle after the first pop.
- Queue {a3=8, 0xAA}; primary writes a3=8, wd=0xBB → GRF gets 0xBB; queued entry later popped with grf_we=0; q_hit for 8 goes 1→0.
- Queue {a3=9, 0x1} then {a3=9, 0x2}; q_addr=9 → q_hit=1, q_data=0x2. q_addr=0 → q_hit=0.
- sec_a3=0 accepted → no GRF write ever. pri_we=1 with pri_a3=0 → queue drains that cycle.
- Assert reset mid-cycle with 3 entries queued → outputs at reset values immediately; after release, no stale write appears and sec_ready=1.
